// File: rtl/right_shift_unit.sv
// Iterative right shifter: coarse STEP-bit moves while enough shift remains, then single-bit moves.
// Logical or arithmetic fill, start/busy/done handshake, all outputs registered.
module right_shift_unit #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned SHAMT_W = 4,
  parameter int unsigned STEP    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   in,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               arith,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   out
);

  typedef enum logic {StIdle, StShift} state_e;

  localparam logic [SHAMT_W-1:0] StepAmt = SHAMT_W'(STEP);
  localparam logic [SHAMT_W-1:0] OneAmt  = SHAMT_W'(1);

  state_e             r_state, w_state_d;
  logic [WIDTH-1:0]   r_data, w_data_d;
  logic [SHAMT_W-1:0] r_rem, w_rem_d;
  logic               r_mode, w_mode_d;
  logic               r_busy, w_busy_d;
  logic               r_done, w_done_d;
  logic [WIDTH-1:0]   r_out, w_out_d;

  logic               w_fill;
  logic [WIDTH-1:0]   w_coarse;
  logic [WIDTH-1:0]   w_fine;

  // Fill bit is the current MSB in arithmetic mode, so the sign never changes.
  assign w_fill   = r_mode & r_data[WIDTH-1];
  assign w_coarse = {{STEP{w_fill}}, r_data[WIDTH-1:STEP]};
  assign w_fine   = {w_fill, r_data[WIDTH-1:1]};

  always_comb begin
    w_state_d = r_state;
    w_data_d  = r_data;
    w_rem_d   = r_rem;
    w_mode_d  = r_mode;
    w_busy_d  = r_busy;
    w_done_d  = 1'b0;
    w_out_d   = r_out;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_data_d  = in;
          w_rem_d   = shamt;
          w_mode_d  = arith;
          w_busy_d  = 1'b1;
          w_state_d = StShift;
        end
      end
      StShift: begin
        if (r_rem >= StepAmt) begin
          w_data_d = w_coarse;
          w_rem_d  = r_rem - StepAmt;
        end else if (r_rem != '0) begin
          w_data_d = w_fine;
          w_rem_d  = r_rem - OneAmt;
        end else begin
          w_out_d   = r_data;
          w_done_d  = 1'b1;
          w_busy_d  = 1'b0;
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_data  <= '0;
      r_rem   <= '0;
      r_mode  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_out   <= '0;
    end else begin
      r_state <= w_state_d;
      r_data  <= w_data_d;
      r_rem   <= w_rem_d;
      r_mode  <= w_mode_d;
      r_busy  <= w_busy_d;
      r_done  <= w_done_d;
      r_out   <= w_out_d;
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign out  = r_out;

endmodule
